// File: rtl/alu_count_sched.sv
// alu_count_sched: two-requester round-robin front end for a bit-serial set-bit count of {argA, argB}.
// Optional build macro ALU_COUNT_EARLY_EXIT_EN ends counting as soon as no set bits remain.
module alu_count_sched #(
  parameter int BITS = 2,
  localparam int LEN = 2 * BITS
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid0,
  input  logic signed [BITS-1:0] i_argA0,
  input  logic signed [BITS-1:0] i_argB0,
  output logic                   o_ready0,
  input  logic                   i_valid1,
  input  logic signed [BITS-1:0] i_argA1,
  input  logic signed [BITS-1:0] i_argB1,
  output logic                   o_ready1,
  output logic                   o_valid,
  output logic [BITS-1:0]        o_result,
  output logic                   o_id,
  input  logic                   i_ready,
  output logic                   o_busy
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [LEN-1:0]  shift_q, shift_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            id_q, id_d;
  logic            ptr_q, ptr_d;
  logic            grant0_s, grant1_s;
  logic            last_s;

  // ptr_q names the requester that wins when both are valid.
  always_comb begin
    grant0_s = i_valid0 && (!i_valid1 || !ptr_q);
    grant1_s = i_valid1 && (!i_valid0 || ptr_q);
  end

`ifdef ALU_COUNT_EARLY_EXIT_EN
  assign last_s = (cnt_q == CW'(LEN - 1)) || ((shift_q >> 1) == '0);
`else
  assign last_s = (cnt_q == CW'(LEN - 1));
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (grant0_s) begin
          shift_d = {i_argA0, i_argB0};
          acc_d   = '0;
          cnt_d   = '0;
          id_d    = 1'b0;
          ptr_d   = 1'b1;
          state_d = S_COUNT;
        end else if (grant1_s) begin
          shift_d = {i_argA1, i_argB1};
          acc_d   = '0;
          cnt_d   = '0;
          id_d    = 1'b1;
          ptr_d   = 1'b0;
          state_d = S_COUNT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COUNT: begin
        // Accumulator is BITS wide on purpose: the count wraps modulo 2^BITS.
        acc_d   = acc_q + BITS'(shift_q[0]);
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COUNT;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_ready0 = (state_q == S_IDLE) && grant0_s;
  assign o_ready1 = (state_q == S_IDLE) && grant1_s;
  assign o_valid  = (state_q == S_DONE);
  assign o_result = acc_q;
  assign o_id     = id_q;
  assign o_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_count_sched.sv
// Scoreboard bench for alu_count_sched: a BITS=2 and a BITS=4 instance, expected results queued by stimulus.
module tb_alu_count_sched;

  typedef struct {
    logic       id;
    logic [3:0] res;
    int         lat;
  } exp_t;

`ifdef ALU_COUNT_EARLY_EXIT_EN
  localparam int L_RR1 = 2;
  localparam int L_T4  = 3;
  localparam int L_U4B = 1;
`else
  localparam int L_RR1 = 4;
  localparam int L_T4  = 4;
  localparam int L_U4B = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, rdy;
  logic [1:0] a0, b0, a1, b1;
  logic       r0, r1, ov, oid, busy;
  logic [1:0] ores;

  logic       v4;
  logic [3:0] a4, b4;
  logic       r40, r41, ov4, oid4, busy4;
  logic [3:0] ores4;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc2 = 0;
  bit fresh2 = 1'b1;
  bit fresh4 = 1'b1;
  exp_t q2[$];
  exp_t q4[$];
  int   t2[$];
  int   t4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_count_sched #(.BITS(2)) u2 (
    .i_clk(clk), .i_rst(rst),
    .i_valid0(v0), .i_argA0(a0), .i_argB0(b0), .o_ready0(r0),
    .i_valid1(v1), .i_argA1(a1), .i_argB1(b1), .o_ready1(r1),
    .o_valid(ov), .o_result(ores), .o_id(oid), .i_ready(rdy), .o_busy(busy)
  );

  alu_count_sched #(.BITS(4)) u4 (
    .i_clk(clk), .i_rst(rst),
    .i_valid0(v4), .i_argA0(a4), .i_argB0(b4), .o_ready0(r40),
    .i_valid1(1'b0), .i_argA1(4'h0), .i_argB1(4'h0), .o_ready1(r41),
    .o_valid(ov4), .o_result(ores4), .o_id(oid4), .i_ready(1'b1), .o_busy(busy4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // BITS=2 monitor: records accepts, checks each presented result against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      q2.delete();
      t2.delete();
      fresh2 = 1'b1;
    end else begin
      chk("ready_onehot", {31'd0, r0 & r1}, 32'd0);
      if ((r0 && v0) || (r1 && v1)) begin
        t2.push_back(cyc + 1);
        acc2++;
      end
      if (ov) begin
        if (q2.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result2: got id=%0d res=%0d, required no result", oid, ores);
        end else begin
          if (fresh2) begin
            if (t2.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL accept_missing2: got result without accept, required an accept");
            end else begin
              chk("latency2", cyc - t2.pop_front(), q2[0].lat);
            end
            fresh2 = 1'b0;
          end
          chk("id2", {31'd0, oid}, {31'd0, q2[0].id});
          chk("result2", {30'd0, ores}, {28'd0, q2[0].res});
          chk("ready_in_done2", {30'd0, r0, r1}, 32'd0);
          if (rdy) begin
            void'(q2.pop_front());
            fresh2 = 1'b1;
          end
        end
      end
    end
  end

  // BITS=4 monitor (downstream always ready).
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      t4.delete();
      fresh4 = 1'b1;
    end else begin
      if (r40 && v4) t4.push_back(cyc + 1);
      if (ov4) begin
        if (q4.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result4: got id=%0d res=%0d, required no result", oid4, ores4);
        end else begin
          if (fresh4 && t4.size() != 0) chk("latency4", cyc - t4.pop_front(), q4[0].lat);
          chk("id4", {31'd0, oid4}, {31'd0, q4[0].id});
          chk("result4", {28'd0, ores4}, {28'd0, q4[0].res});
          void'(q4.pop_front());
          fresh4 = 1'b1;
        end
      end
    end
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q2.size() != 0 || q4.size() != 0); i++) tick(1);
    chk("drain2", q2.size(), 0);
    chk("drain4", q4.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; v0 = 1'b0; v1 = 1'b0; v4 = 1'b0;
    a0 = 2'd0; b0 = 2'd0; a1 = 2'd0; b1 = 2'd0; a4 = 4'h0; b4 = 4'h0;
    tick(3);
    chk("rst_valid", {31'd0, ov}, 32'd0);
    chk("rst_result", {30'd0, ores}, 32'd0);
    chk("rst_id", {31'd0, oid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(1);

    // A=11 B=01: three set bits
    q2.push_back('{1'b0, 4'd3, 4});
    a0 = 2'b11; b0 = 2'b01; v0 = 1'b1;
    #1 chk("ready0_idle", {31'd0, r0}, 32'd1);
    tick(1);
    v0 = 1'b0;
    drain(30);

    // A=11 B=11: four set bits wrap to 0
    q2.push_back('{1'b0, 4'd0, 4});
    a0 = 2'b11; b0 = 2'b11; v0 = 1'b1;
    tick(1);
    v0 = 1'b0;
    drain(30);

    // Round robin after reset: first grant to requester 0
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    a0 = 2'b10; b0 = 2'b00; a1 = 2'b00; b1 = 2'b11;
    q2.push_back('{1'b0, 4'd1, 4});
    q2.push_back('{1'b1, 4'd2, L_RR1});
    q2.push_back('{1'b0, 4'd1, 4});
    q2.push_back('{1'b1, 4'd2, L_RR1});
    v0 = 1'b1; v1 = 1'b1;
    #1 chk("rr_first_ready0", {30'd0, r0, r1}, 32'd2);
    begin
      int base;
      base = acc2;
      for (int i = 0; i < 80 && (acc2 - base) < 4; i++) tick(1);
      chk("rr_accepts", acc2 - base, 4);
    end
    v0 = 1'b0; v1 = 1'b0;
    drain(40);

    // Backpressure: hold DONE five cycles, then accept right after the handshake
    rdy = 1'b0;
    a0 = 2'b01; b0 = 2'b10;
    q2.push_back('{1'b0, 4'd2, L_T4});
    q2.push_back('{1'b0, 4'd2, L_T4});
    v0 = 1'b1;
    tick(1);
    for (int i = 0; i < 20 && !ov; i++) tick(1);
    chk("bp_valid", {31'd0, ov}, 32'd1);
    tick(5);
    chk("bp_still_valid", {31'd0, ov}, 32'd1);
    rdy = 1'b1;
    tick(1);
    #1 chk("bp_ready_after_hs", {31'd0, r0}, 32'd1);
    tick(1);
    v0 = 1'b0;
    drain(30);

    // Reset mid-COUNT discards the request
    q2.push_back('{1'b0, 4'd0, 4});
    a0 = 2'b11; b0 = 2'b11; v0 = 1'b1;
    tick(1);
    v0 = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, ov}, 32'd0);
    tick(10);
    chk("abort_queue", q2.size(), 0);

    // BITS=4 instance
    q4.push_back('{1'b0, 4'd5, 8});
    a4 = 4'hF; b4 = 4'h1; v4 = 1'b1;
    tick(1);
    v4 = 1'b0;
    drain(30);
    q4.push_back('{1'b0, 4'd1, L_U4B});
    a4 = 4'h0; b4 = 4'h1; v4 = 1'b1;
    tick(1);
    v4 = 1'b0;
    drain(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_count_sched.md
# alu_count_sched

Sequential front end for the ALU bit-count operation. Two requesters share one bit-serial counting engine that returns the number of set bits in the concatenation {argA, argB}, the same function and width rule as the ALU's combinational bit-count unit. The block arbitrates round-robin between the requesters, sequences the count over multiple cycles, and holds the result under a valid/ready handshake toward the ALU result path.

## Interface
- BITS, default 2: operand width; result width.
- LEN, default 2*BITS: count vector width. Derived; never overridden.

- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid0  input  1  requester 0 has an operand pair.
- i_argA0, i_argB0  input  BITS each  requester 0 operands, signed type, treated as raw bits.
- o_ready0  output  1  requester 0 accepted this cycle when i_valid0 is high.
- i_valid1, i_argA1, i_argB1, o_ready1: same as the requester 0 ports, for requester 1.
- o_valid  output  1  result available.
- o_result  output  BITS  set-bit count modulo 2^BITS.
- o_id  output  1  requester that owns o_result.
- i_ready  input  1  downstream accepts the result.
- o_busy  output  1  state is not IDLE.

## Operation
- FSM states: IDLE, COUNT, DONE.
- **IDLE**
  - Grant is combinational from i_valid0, i_valid1 and the priority pointer.
  - Only one valid requester: that requester is granted.
  - Both requesters valid: the requester the pointer names is granted.
  - o_readyN = (state==IDLE) && grantN. At most one ready is high in a cycle.
  - On accept: load shift register with {argA, argB}, argB[0] as LSB. Clear the accumulator and bit counter. Latch o_id. Pointer moves to the requester that was not granted. Go to COUNT.
- **COUNT**, each cycle:
  - acc <= acc + shift[0], truncated to BITS bits.
  - shift <= shift >> 1.
  - cnt <= cnt + 1.
  - Exit to DONE on the cycle where cnt == LEN-1, so COUNT lasts exactly LEN cycles.
- **DONE**
  - o_valid=1, with o_result=acc and o_id held stable.
  - On o_valid && i_ready: go to IDLE.
  - No new request is accepted while in DONE.
- Arithmetic: the full count 0..LEN is computed and wraps modulo 2^BITS. Example: BITS=2 with all ones gives 4, which wraps to 0.
- Requester hold rule: operands must stay stable only in the accept cycle. They are sampled once, at accept.
- Reset while in any state:
  - Next state IDLE. The in-flight request is discarded and no result is issued.
  - Pointer returns to requester 0.

## Timing
- Reset values:
  - o_valid=0, o_result=0, o_id=0, o_busy=0.
  - o_ready0/o_ready1 follow the IDLE grant logic, so o_ready0=1 right after reset if i_valid0=1.
- Latency:
  - Accept happens at edge T.
  - COUNT occupies edges T+1..T+LEN.
  - o_valid is high in the cycle following edge T+LEN, which is LEN cycles after acceptance.
- Throughput:
  - The output handshake happens at edge U. The block is IDLE in cycle U+1 and can accept at edge U+1.
  - With i_ready held high, one result is produced per LEN+2 cycles.
- Backpressure: i_ready low holds DONE indefinitely with outputs unchanged.
- Simultaneous events:
  - Both valid at once: the pointer decides the grant.
  - i_rst together with a handshake: reset wins.

## Configuration
- Macro: ALU_COUNT_EARLY_EXIT_EN.
- Defined:
  - COUNT exits to DONE when the shifted value (shift >> 1) is zero, or when cnt == LEN-1.
  - Latency becomes 1 + the index of the highest set bit of {argA, argB}.
  - An all-zero vector takes 1 cycle, giving result 0.
  - The result is identical to the undefined case.
- Undefined: fixed LEN-cycle COUNT as specified above.

## Test plan
- BITS=2, requester 0 sends A=2'b11, B=2'b01, i_ready=1 -> o_valid 4 cycles after accept, o_result=3, o_id=0.
- BITS=2, A=2'b11, B=2'b11 -> o_result=0 (wrap of 4). BITS=4, A=4'hF, B=4'h1 -> o_result=5.
- Both requesters valid continuously with distinct operands -> o_id sequence 0,1,0,1. Each result matches its requester's operands. After reset the first grant goes to requester 0.
- Result in DONE, i_ready low for 5 cycles -> o_valid, o_result and o_id stable; o_ready0 and o_ready1 stay 0. On i_ready=1, accept occurs in the following cycle.
- i_rst pulsed mid-COUNT -> next cycle IDLE, o_valid=0, o_busy=0, and no result for the aborted request ever appears.
- BITS=4, A=4'h0, B=4'h1 -> with ALU_COUNT_EARLY_EXIT_EN, o_valid 1 cycle after accept; without it, 8 cycles. o_result=1 in both cases.
